uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
//  Serial program loader sitting directly upstream of the 16-bit x 4096-word
//  instruction/data BRAM. Receives a UART byte stream (8N1), assembles
//  big-endian 16-bit words and writes them to consecutive RAM addresses from 0.
//  Drives the RAM data/wren/address port during boot. Flags done so the CPU can
//  be released from hold, or err on a malformed stream.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200); must be >= 4
//  ADDR_W        12   RAM address width; capacity = 2**ADDR_W words
//  DATA_W        16   RAM word width; fixed at 2 bytes per word
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  uart_rx      in   1       serial input, idle high, asynchronous to clk
//  ram_data     out  16      write data to RAM data port
//  ram_wren     out  1       one-cycle write strobe to RAM wren
//  ram_address  out  12      word address to RAM address port
//  busy         out  1       load in progress (length header started)
//  done         out  1       load complete; sticky until reset
//  err          out  1       framing or length error; sticky until reset
// BEHAVIOUR
//  Reset: all outputs 0. RX FSM in RX_IDLE, loader FSM in L_LEN_HI, counters 0.
//  RX path: uart_rx through 2-flop synchroniser before any use.
//  RX FSM: RX_IDLE -> RX_START on synced low; sample at CLKS_PER_BIT/2.
//   Start not still low -> RX_IDLE, no byte (glitch reject).
//   RX_DATA: 8 bits LSB first, each sampled mid-bit (every CLKS_PER_BIT clks).
//   RX_STOP: sample mid-bit. High -> byte_valid pulses 1 clk in that cycle.
//   Low -> frame_err pulses 1 clk. Either way -> RX_IDLE (no wait for idle).
//  Stream format: LEN_HI, LEN_LO (word count N, big-endian), then N words,
//   each as HI byte then LO byte.
//  Loader FSM (advances only on byte_valid):
//   L_LEN_HI -> L_LEN_LO: store len[15:8]; busy <= 1.
//   L_LEN_LO: store len[7:0]. N==0 -> L_DONE. N>2**ADDR_W -> L_ERR.
//    Otherwise -> L_DAT_HI.
//   L_DAT_HI -> L_DAT_LO: store hi byte.
//   L_DAT_LO: in the clk after byte_valid: ram_wren=1 for exactly 1 clk,
//    ram_address=word index, ram_data={hi,lo}. Index increments after the write.
//    Last word (index==N-1) -> L_DONE; else -> L_DAT_HI.
//   L_DONE: done=1, busy=0; further bytes ignored; no writes.
//   L_ERR: err=1, busy=0; further bytes ignored; no writes.
//   frame_err in any state except L_DONE -> L_ERR.
//  Latency: stop-bit mid-sample to ram_wren high = 1 clk.
//  ram_address/ram_data hold their last values after a write. ram_wren is 0
//   outside write cycles, so the RAM reads at the held address.
//  Address never wraps: N capped at 2**ADDR_W; max address 4095.
//  Reset mid-operation: everything aborts to reset state. A partial word is
//   discarded; words already written stay in RAM. Next load starts at address 0.
// TESTING (sim with CLKS_PER_BIT=4)
//  1. Bytes 00 02 80 20 81 03 -> wren pulse addr 0 data 0x8020, then addr 1
//     data 0x8103; done=1, busy=0, err=0.
//  2. Bytes 00 00 -> no wren; done=1 one clk after 2nd stop sample.
//  3. Bytes 10 01 (N=4097) -> err=1, no wren; later bytes ignored.
//  4. Bytes 00 01 A5 with stop bit forced low on A5 -> err=1, no wren, done=0.
//  5. uart_rx low for 1 clk only -> no byte_valid, FSMs unchanged.
//     Next valid stream then loads normally.
//  6. Bytes 00 02 12; assert rst_n=0 mid-byte of 4th byte -> all outputs 0.
//     Resend 00 01 BE EF -> single write addr 0 data 0xBEEF, done=1.

Source files
------------

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: boot-time serial program loader.
// Receives an 8N1 UART byte stream, takes a big-endian 16-bit word count,
// then assembles big-endian 16-bit words and writes them to consecutive
// RAM addresses starting at 0. Flags done on a complete load and err on a
// framing error or an oversized word count.
// ADDR_W is limited to 16 so that the capacity compare fits in 17 bits.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_address,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [16:0]      CAPACITY = 17'(2 ** ADDR_W);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_LEN_HI,
        L_LEN_LO,
        L_DAT_HI,
        L_DAT_LO,
        L_DONE,
        L_ERR
    } ld_state_t;

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             stop_sample;
    logic             byte_valid;
    logic             frame_err;
    logic [7:0]       rx_byte;

    ld_state_t        ld_state;
    logic [7:0]       len_hi;
    logic [7:0]       word_hi;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] last_idx;
    logic [15:0]      len_word;

    // Two-flop synchroniser; resets to the idle-high line level so reset
    // release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver FSM: half-bit start check, then one sample per bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        // A start bit that has gone high again is a glitch
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Byte/frame-error strobes are asserted in the stop-bit sample cycle so
    // the loader can register the RAM write one clock later.
    assign stop_sample = (rx_state == RX_STOP) && (rx_cnt == FULL_M1);
    assign byte_valid  = stop_sample && rx_sync;
    assign frame_err   = stop_sample && !rx_sync;
    assign rx_byte     = rx_shift;
    assign len_word    = {len_hi, rx_byte};

    // Loader FSM with registered RAM port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state    <= L_LEN_HI;
            len_hi      <= '0;
            word_hi     <= '0;
            word_idx    <= '0;
            last_idx    <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            ram_address <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            ram_wren <= 1'b0;
            if (frame_err && (ld_state != L_DONE)) begin
                ld_state <= L_ERR;
                err      <= 1'b1;
                busy     <= 1'b0;
            end else if (byte_valid) begin
                case (ld_state)
                    L_LEN_HI: begin
                        len_hi   <= rx_byte;
                        busy     <= 1'b1;
                        ld_state <= L_LEN_LO;
                    end
                    L_LEN_LO: begin
                        if (len_word == 16'd0) begin
                            ld_state <= L_DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                        end else if ({1'b0, len_word} > CAPACITY) begin
                            ld_state <= L_ERR;
                            err      <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            // N is at most the capacity, so N-1 fits the address
                            last_idx <= ADDR_W'(len_word - 16'd1);
                            word_idx <= '0;
                            ld_state <= L_DAT_HI;
                        end
                    end
                    L_DAT_HI: begin
                        word_hi  <= rx_byte;
                        ld_state <= L_DAT_LO;
                    end
                    L_DAT_LO: begin
                        ram_wren    <= 1'b1;
                        ram_address <= word_idx;
                        ram_data    <= DATA_W'({word_hi, rx_byte});
                        word_idx    <= word_idx + ADDR_W'(1);
                        if (word_idx == last_idx) begin
                            ld_state <= L_DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            ld_state <= L_DAT_HI;
                        end
                    end
                    default: begin
                        // L_DONE and L_ERR ignore further bytes
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Testbench for uart_prog_loader: table-driven streams, hand-written
// corner sequences (latency, glitch, mid-byte reset) and randomized streams
// checked against a stream-level reference model.
module tb_uart_prog_loader;

    localparam int CPB = 4;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        uart_rx = 1'b1;
    logic [15:0] ram_data;
    logic        ram_wren;
    logic [11:0] ram_address;
    logic        busy;
    logic        done;
    logic        err;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (12),
        .DATA_W      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .ram_address(ram_address),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [11:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t  wr_q[$];
    int   dbl_cnt   = 0;
    logic prev_wren = 1'b0;

    // Write monitor: log every RAM write and count multi-cycle strobes
    always @(negedge clk) begin
        if (ram_wren === 1'b1) wr_q.push_back({ram_address, ram_data});
        if (ram_wren === 1'b1 && prev_wren === 1'b1) dbl_cnt <= dbl_cnt + 1;
        prev_wren <= ram_wren;
    end

    logic [7:0] stim_q[$];
    int         stim_bad;
    wr_t        exp_q[$];
    bit         exp_busy, exp_done, exp_err;

    typedef struct {
        logic [63:0] bytes;
        int          nbytes;
        int          bad;
        bit          e_busy;
        bit          e_done;
        bit          e_err;
        int          e_nw;
        logic [27:0] e_last;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        wr_q.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_stream(input int max_gap);
        for (int i = 0; i < stim_q.size(); i++) begin
            send_byte(stim_q[i], (i == stim_bad) ? 1'b0 : 1'b1);
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
        repeat (8) @(negedge clk);
    endtask

    // Reference: bytes before the first bad stop bit count; length header,
    // then as many complete words as arrived, capped at N.
    function automatic void build_model();
        int  k;
        int  n_len;
        int  words;
        wr_t w;
        exp_q.delete();
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        k = (stim_bad >= 0) ? stim_bad : stim_q.size();
        if (k == 0) begin
            exp_err = (stim_bad >= 0);
        end else if (k == 1) begin
            if (stim_bad >= 0) exp_err = 1'b1;
            else exp_busy = 1'b1;
        end else begin
            n_len = int'({stim_q[0], stim_q[1]});
            if (n_len == 0) begin
                exp_done = 1'b1;
            end else if (n_len > 4096) begin
                exp_err = 1'b1;
            end else begin
                words = (k - 2) / 2;
                if (words > n_len) words = n_len;
                for (int i = 0; i < words; i++) begin
                    w.a = 12'(i);
                    w.d = {stim_q[2 + 2 * i], stim_q[3 + 2 * i]};
                    exp_q.push_back(w);
                end
                if (words == n_len) exp_done = 1'b1;
                else if (stim_bad >= 0) exp_err = 1'b1;
                else exp_busy = 1'b1;
            end
        end
    endfunction

    task automatic check_result(input string tag, input int dbl_before);
        build_model();
        $display("[TB] %s: %0d bytes, %0d writes, busy=%0b done=%0b err=%0b",
                 tag, stim_q.size(), wr_q.size(), busy, done, err);
        chk({tag, " busy"}, 32'(busy), 32'(exp_busy));
        chk({tag, " done"}, 32'(done), 32'(exp_done));
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        chk({tag, " nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            chk($sformatf("%s wr%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
        end
        if (exp_q.size() > 0) begin
            chk({tag, " hold addr"}, 32'(ram_address), 32'(exp_q[exp_q.size() - 1].a));
            chk({tag, " hold data"}, 32'(ram_data), 32'(exp_q[exp_q.size() - 1].d));
        end
        chk({tag, " wren width"}, 32'(dbl_cnt), 32'(dbl_before));
        chk({tag, " wren idle"}, 32'(ram_wren), 32'(0));
    endtask

    function automatic vec_t mk(input logic [63:0] bytes, input int nb, input int bad,
                                input bit eb, input bit ed, input bit ee,
                                input int nw, input logic [27:0] last);
        vec_t v;
        v.bytes  = bytes;
        v.nbytes = nb;
        v.bad    = bad;
        v.e_busy = eb;
        v.e_done = ed;
        v.e_err  = ee;
        v.e_nw   = nw;
        v.e_last = last;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    d0;
        int    mode;
        int    n;
        int    len;
        int    cut;
        string tag;

        vecs[0] = mk(64'h0002_8020_8103_0000, 6, -1, 1'b0, 1'b1, 1'b0, 2, 28'h001_8103);
        vecs[1] = mk(64'h0000_0000_0000_0000, 2, -1, 1'b0, 1'b1, 1'b0, 0, 28'h0);
        vecs[2] = mk(64'h1001_1234_5678_0000, 6, -1, 1'b0, 1'b0, 1'b1, 0, 28'h0);
        vecs[3] = mk(64'h0001_A500_0000_0000, 3, 2,  1'b0, 1'b0, 1'b1, 0, 28'h0);
        vecs[4] = mk(64'h1000_1122_3344_0000, 6, -1, 1'b1, 1'b0, 1'b0, 2, 28'h001_3344);
        vecs[5] = mk(64'h0001_BEEF_5566_0000, 6, -1, 1'b0, 1'b1, 1'b0, 1, 28'h000_BEEF);
        vecs[6] = mk(64'h0003_0102_0304_0000, 6, -1, 1'b1, 1'b0, 1'b0, 2, 28'h001_0304);
        vecs[7] = mk(64'h0001_1234_0000_0000, 4, 3,  1'b0, 1'b0, 1'b1, 0, 28'h0);

        // Reset state
        @(negedge clk);
        chk("reset ram_data", 32'(ram_data), 32'(0));
        chk("reset ram_wren", 32'(ram_wren), 32'(0));
        chk("reset ram_address", 32'(ram_address), 32'(0));
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset done", 32'(done), 32'(0));
        chk("reset err", 32'(err), 32'(0));

        // Table-driven streams
        for (int v = 0; v < 8; v++) begin
            do_reset();
            stim_q.delete();
            for (int i = 0; i < vecs[v].nbytes; i++) stim_q.push_back(vecs[v].bytes[63 - 8 * i -: 8]);
            stim_bad = vecs[v].bad;
            d0 = dbl_cnt;
            send_stream(1);
            tag = $sformatf("vec%0d", v);
            check_result(tag, d0);
            chk({tag, " tbl busy"}, 32'(busy), 32'(vecs[v].e_busy));
            chk({tag, " tbl done"}, 32'(done), 32'(vecs[v].e_done));
            chk({tag, " tbl err"}, 32'(err), 32'(vecs[v].e_err));
            chk({tag, " tbl nwrites"}, 32'(wr_q.size()), 32'(vecs[v].e_nw));
            if (vecs[v].e_nw > 0) begin
                chk({tag, " tbl last"}, 32'({ram_address, ram_data}), 32'(vecs[v].e_last));
            end
        end

        // Write latency: wren exactly one clock after the final stop sample
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hCA, 1'b1);
        send_byte(8'hFE, 1'b1);
        chk("lat pre wren", 32'(ram_wren), 32'(0));
        @(negedge clk);
        chk("lat wren", 32'(ram_wren), 32'(1));
        chk("lat addr", 32'(ram_address), 32'(0));
        chk("lat data", 32'(ram_data), 32'(16'hCAFE));
        chk("lat done", 32'(done), 32'(1));
        @(negedge clk);
        chk("lat wren low", 32'(ram_wren), 32'(0));
        $display("[TB] latency: write 0x%0h at addr %0d", ram_data, ram_address);

        // Zero-length: done one clock after the second stop sample
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("n0 done pre", 32'(done), 32'(0));
        chk("n0 busy pre", 32'(busy), 32'(1));
        @(negedge clk);
        chk("n0 done", 32'(done), 32'(1));
        chk("n0 busy", 32'(busy), 32'(0));
        $display("[TB] zero length: done=%0b busy=%0b", done, busy);

        // Single-clock glitch is rejected, then a normal load follows
        do_reset();
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch busy", 32'(busy), 32'(0));
        chk("glitch nwrites", 32'(wr_q.size()), 32'(0));
        stim_q = '{8'h00, 8'h01, 8'h12, 8'h34};
        stim_bad = -1;
        d0 = dbl_cnt;
        send_stream(1);
        check_result("glitch then load", d0);

        // Reset during the fourth byte aborts; a new load starts at address 0
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        uart_rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        chk("midrst busy before", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst ram_data", 32'(ram_data), 32'(0));
        chk("midrst ram_wren", 32'(ram_wren), 32'(0));
        chk("midrst ram_address", 32'(ram_address), 32'(0));
        chk("midrst busy", 32'(busy), 32'(0));
        chk("midrst done", 32'(done), 32'(0));
        chk("midrst err", 32'(err), 32'(0));
        @(negedge clk);
        uart_rx = 1'b1;
        wr_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        stim_q = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        stim_bad = -1;
        d0 = dbl_cnt;
        send_stream(1);
        check_result("after midrst", d0);
        chk("after midrst write", 32'(wr_q.size() > 0 ? wr_q[0] : '0), 32'({12'd0, 16'hBEEF}));

        // Randomized streams against the reference model
        for (int r = 0; r < 20; r++) begin
            stim_q.delete();
            stim_bad = -1;
            mode = int'($urandom_range(0, 5));
            n = int'($urandom_range(1, 5));
            case (mode)
                3: begin
                    cut = int'($urandom_range(0, 2));
                    len = (cut == 0) ? 0 : (cut == 1) ? 4096 : int'($urandom_range(4097, 65535));
                    n = 2;
                end
                default: len = n;
            endcase
            stim_q.push_back(8'(len >> 8));
            stim_q.push_back(8'(len));
            for (int i = 0; i < 2 * n + int'($urandom_range(0, 2)); i++) stim_q.push_back(8'($urandom));
            if (mode == 4) begin
                cut = int'($urandom_range(1, stim_q.size() - 2));
                for (int i = 0; i < cut; i++) void'(stim_q.pop_back());
            end
            if (mode == 5) stim_bad = int'($urandom_range(0, stim_q.size() - 1));
            do_reset();
            d0 = dbl_cnt;
            send_stream(3);
            check_result($sformatf("rand%0d mode%0d len%0d", r, mode, len), d0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
